// File: rtl/ksa_wb_sequencer_if.sv
// Wishbone slave bundle for ksa_wb_sequencer: the management SoC drives the master side,
// the sequencer receives it through the slave modport.
interface ksa_wb_sequencer_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ksa_wb_sequencer.sv
// Wishbone front end for the 16-bit adder: operand FIFO -> registered operands -> result FIFO.
// Define KSA_ACCUM_EN to feed each sum back as the next a-operand when CTRL[2] is set.
module ksa_wb_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    ksa_wb_sequencer_if.slave wbs,
    output logic [15:0]       add_a_o,
    output logic [15:0]       add_b_o,
    input  logic [15:0]       add_sum_i,
    input  logic              add_cout_i,
    output logic              irq_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, CAPTURE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   opMem_q [DEPTH];
    logic [16:0]   resMem_q [DEPTH];
    logic [PW-1:0] opWr_q, opRd_q, resWr_q, resRd_q;
    logic [3:0]    opCnt_q, resCnt_q;
    logic          ack_q;
    logic [31:0]   dat_q;
    logic          enable_q, irqEn_q, ovf_q, udf_q, irq_q;

    logic          opEmpty, opFull, resEmpty, resFull;
    logic          wbReq, wbWr, wbRd, ctrlWr;
    logic [1:0]    regSel;
    logic          wbPush, wbPop, wbOvf, wbUdf, fsmPop, fsmPush;
    logic [31:0]   opHead, rdData;
    logic [16:0]   resHead;
    logic          ctrlAccum;
    logic [15:0]   accVal;
    logic          unusedBits;

    assign unusedBits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0]};

    assign opEmpty  = (opCnt_q == 4'd0);
    assign opFull   = (opCnt_q == 4'(DEPTH));
    assign resEmpty = (resCnt_q == 4'd0);
    assign resFull  = (resCnt_q == 4'(DEPTH));
    assign opHead   = opMem_q[opRd_q];
    assign resHead  = resMem_q[resRd_q];

    // A request is taken only while ack is low, which forces one idle cycle between accesses.
    assign wbReq  = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    assign wbWr   = wbReq & wbs.wbs_we_i;
    assign wbRd   = wbReq & ~wbs.wbs_we_i;
    assign regSel = wbs.wbs_adr_i[3:2];
    assign ctrlWr = wbWr & (regSel == 2'd3);
    assign wbPush = wbWr & (regSel == 2'd0) & ~opFull;
    assign wbOvf  = wbWr & (regSel == 2'd0) & opFull;
    assign wbPop  = wbRd & (regSel == 2'd1) & ~resEmpty;
    assign wbUdf  = wbRd & (regSel == 2'd1) & resEmpty;

    always_comb begin
        rdData = 32'h0;
        case (regSel)
            2'd1:    rdData = resEmpty ? 32'h0 : {15'h0, resHead};
            2'd2:    rdData = {16'h0, resCnt_q, opCnt_q, 2'b00, udf_q, ovf_q,
                               resFull, resEmpty, opFull, opEmpty};
            2'd3:    rdData = {29'h0, ctrlAccum, irqEn_q, enable_q};
            default: rdData = 32'h0;
        endcase
    end

    // Issue only when the result FIFO has room, so the eventual capture always has a slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fsmPop  = 1'b0;
        fsmPush = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_q && !opEmpty && !resFull) begin
                    fsmPop  = 1'b1;
                    a_d     = ctrlAccum ? accVal : opHead[15:0];
                    b_d     = opHead[31:16];
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                fsmPush = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 16'h0;
            b_q     <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wbPush) opMem_q[opWr_q] <= wbs.wbs_dat_i;
        if (fsmPush) resMem_q[resWr_q] <= {add_cout_i, add_sum_i};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            opWr_q   <= '0;
            opRd_q   <= '0;
            resWr_q  <= '0;
            resRd_q  <= '0;
            opCnt_q  <= 4'd0;
            resCnt_q <= 4'd0;
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            enable_q <= 1'b0;
            irqEn_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= wbReq;
            dat_q <= wbRd ? rdData : 32'h0;
            if (wbPush) opWr_q <= opWr_q + PW'(1);
            if (fsmPop) opRd_q <= opRd_q + PW'(1);
            if (fsmPush) resWr_q <= resWr_q + PW'(1);
            if (wbPop) resRd_q <= resRd_q + PW'(1);
            case ({wbPush, fsmPop})
                2'b10:   opCnt_q <= opCnt_q + 4'd1;
                2'b01:   opCnt_q <= opCnt_q - 4'd1;
                default: opCnt_q <= opCnt_q;
            endcase
            case ({fsmPush, wbPop})
                2'b10:   resCnt_q <= resCnt_q + 4'd1;
                2'b01:   resCnt_q <= resCnt_q - 4'd1;
                default: resCnt_q <= resCnt_q;
            endcase
            if (ctrlWr) begin
                enable_q <= wbs.wbs_dat_i[0];
                irqEn_q  <= wbs.wbs_dat_i[1];
            end
            if (wbOvf) ovf_q <= 1'b1;
            else if (wbWr && regSel == 2'd2 && wbs.wbs_dat_i[4]) ovf_q <= 1'b0;
            if (wbUdf) udf_q <= 1'b1;
            else if (wbWr && regSel == 2'd2 && wbs.wbs_dat_i[5]) udf_q <= 1'b0;
            irq_q <= irqEn_q & ~resEmpty;
        end
    end

`ifdef KSA_ACCUM_EN
    logic        accumEn_q;
    logic [15:0] acc_q;

    // A CTRL write with bit 2 clear restarts the running sum from zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            accumEn_q <= 1'b0;
            acc_q     <= 16'h0;
        end else begin
            if (ctrlWr) accumEn_q <= wbs.wbs_dat_i[2];
            if (ctrlWr && !wbs.wbs_dat_i[2]) acc_q <= 16'h0;
            else if (fsmPush) acc_q <= add_sum_i;
        end
    end

    assign ctrlAccum = accumEn_q;
    assign accVal    = acc_q;
`else
    assign ctrlAccum = 1'b0;
    assign accVal    = 16'h0;
`endif

    assign add_a_o       = a_q;
    assign add_b_o       = b_q;
    assign irq_o         = irq_q;
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_ksa_wb_sequencer.sv
// Scoreboard bench for ksa_wb_sequencer: bus accesses queue their expected read data and a
// monitor checks each acknowledged read; a behavioural adder closes the loop.
module tb_ksa_wb_sequencer;
    logic        clk;
    logic        wb_rst_i;
    logic [15:0] addA, addB, addSum;
    logic        addCout, irq;

    int compared   = 0;
    int mismatched = 0;
    logic [32:0] expQ[$];
    string       nameQ[$];
    logic        prevAck = 1'b0;

    ksa_wb_sequencer_if bus();

    ksa_wb_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .wbs        (bus),
        .add_a_o    (addA),
        .add_b_o    (addB),
        .add_sum_i  (addSum),
        .add_cout_i (addCout),
        .irq_o      (irq)
    );

    assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every ack consumes one scoreboard entry; read entries are compared.
    always @(negedge clk) begin
        logic [32:0] e;
        string       n;
        if (wb_rst_i && bus.wbs_ack_o) begin
            compared++;
            if (prevAck) begin
                mismatched++;
                $display("[TB] FAIL ack_spacing: ack high in consecutive cycles, required one-cycle pulse");
            end
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ack: ack with no pending access");
            end else begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                if (e[32]) begin
                    compared++;
                    if (bus.wbs_dat_o !== e[31:0]) begin
                        mismatched++;
                        $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", n, bus.wbs_dat_o, e[31:0]);
                    end
                end
            end
        end
        prevAck = bus.wbs_ack_o;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] regSel, input logic [31:0] data,
                                 input logic [31:0] exp, input string name);
        bit gotAck = 1'b0;
        expQ.push_back({~we, exp});
        nameQ.push_back(name);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = {28'h0, regSel, 2'b00};
        bus.wbs_dat_i = data;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) begin
                gotAck = 1'b1;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!gotAck) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: no ack within 20 cycles, required ack", name);
            void'(expQ.pop_back());
            void'(nameQ.pop_back());
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] exp);
        compared++;
        if (actual !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, exp);
        end
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        wb_rst_i = 1'b0;
        waitCycles(2);
        checkOutput("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        checkOutput("rst_dat", bus.wbs_dat_o, 32'h0);
        checkOutput("rst_a", {16'h0, addA}, 32'h0);
        checkOutput("rst_b", {16'h0, addB}, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        wb_rst_i = 1'b1;
        waitCycles(1);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0005, "rst_status");
        applyStimulus(1'b0, 2'd3, 32'h0, 32'h0000_0000, "rst_ctrl");

        $display("[TB] basic add");
        applyStimulus(1'b1, 2'd3, 32'h1, 32'h0, "wr_ctrl");
        applyStimulus(1'b1, 2'd0, 32'h0003_0005, 32'h0, "wr_op");
        waitCycles(3);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_1001, "basic_status_pending");
        checkOutput("basic_irq_gated", {31'h0, irq}, 32'h0);
        checkOutput("basic_a_held", {16'h0, addA}, 32'h5);
        checkOutput("basic_b_held", {16'h0, addB}, 32'h3);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0000_0008, "basic_result");
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0005, "basic_status_after");
        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0000_0000, "operand_read_zero");

        $display("[TB] carry");
        applyStimulus(1'b1, 2'd0, 32'h0001_FFFF, 32'h0, "wr_op");
        waitCycles(3);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0001_0000, "carry_result1");
        applyStimulus(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, "wr_op");
        waitCycles(3);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0001_FFFE, "carry_result2");

        $display("[TB] overflow / underflow");
        applyStimulus(1'b1, 2'd3, 32'h0, 32'h0, "wr_ctrl");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 2'd0, {16'(i), 16'(i)}, 32'h0, "wr_op");
        end
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0416, "ovf_status");
        applyStimulus(1'b1, 2'd3, 32'h1, 32'h0, "wr_ctrl");
        waitCycles(20);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_4019, "res_full_status");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 2'd1, 32'h0, 32'(2 * i), "ovf_result");
        end
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0, "underflow_read");
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0035, "udf_status");
        applyStimulus(1'b1, 2'd2, 32'h30, 32'h0, "wr_status_clear");
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0005, "cleared_status");

        $display("[TB] irq");
        applyStimulus(1'b1, 2'd3, 32'h3, 32'h0, "wr_ctrl");
        checkOutput("irq_idle", {31'h0, irq}, 32'h0);
        applyStimulus(1'b1, 2'd0, 32'h0002_0002, 32'h0, "wr_op");
        waitCycles(5);
        checkOutput("irq_pending", {31'h0, irq}, 32'h1);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0000_0004, "irq_result");
        checkOutput("irq_still_high", {31'h0, irq}, 32'h1);
        waitCycles(1);
        checkOutput("irq_dropped", {31'h0, irq}, 32'h0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 2'd0, 32'h0007_0009, 32'h0, "wr_op");
        waitCycles(1);
        checkOutput("hold_a", {16'h0, addA}, 32'h9);
        checkOutput("hold_b", {16'h0, addB}, 32'h7);
        wb_rst_i = 1'b0;
        #1;
        checkOutput("midrst_a", {16'h0, addA}, 32'h0);
        checkOutput("midrst_b", {16'h0, addB}, 32'h0);
        checkOutput("midrst_irq", {31'h0, irq}, 32'h0);
        checkOutput("midrst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        waitCycles(2);
        @(negedge clk);
        wb_rst_i = 1'b1;
        waitCycles(1);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0005, "midrst_status");
        waitCycles(6);
        checkOutput("midrst_no_irq", {31'h0, irq}, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0000_0005, "midrst_status_later");

`ifdef KSA_ACCUM_EN
        $display("[TB] accumulate");
        applyStimulus(1'b1, 2'd3, 32'h5, 32'h0, "wr_ctrl");
        applyStimulus(1'b0, 2'd3, 32'h0, 32'h0000_0005, "accum_ctrl");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd0, 32'h8000_0000, 32'h0, "wr_op");
        end
        waitCycles(15);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0000_8000, "accum_result1");
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0001_0000, "accum_result2");
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0000_8000, "accum_result3");
`else
        $display("[TB] accumulate bit not present");
        applyStimulus(1'b1, 2'd3, 32'h5, 32'h0, "wr_ctrl");
        applyStimulus(1'b0, 2'd3, 32'h0, 32'h0000_0001, "ctrl_no_accum");
        applyStimulus(1'b1, 2'd0, 32'h8000_0000, 32'h0, "wr_op");
        waitCycles(4);
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0000_8000, "no_accum_result");
`endif

        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
